// File: rtl/hex_count_sequencer_pkg.sv
// Shared types and helpers for the six-digit BCD count sequencer.
package hex_count_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam int         NUM_DIGITS = 6;
   localparam logic [3:0] BCD_MAX    = 4'd9;

   // Non-decimal nibbles are not representable on the display; force them to 0.
   function automatic logic [3:0] bcd_sanitize(input logic [3:0] nib);
      return (nib > BCD_MAX) ? 4'd0 : nib;
   endfunction

endpackage

// File: rtl/hex_count_sequencer_bcd_digit.sv
// One BCD digit of the carry chain: clear > load > increment.
// The digit only advances when inc is set and every lower digit is 9 (carry_in).
module bcd_digit
   import hex_count_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clear,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       inc,
   input  logic       carry_in,
   output logic [3:0] q,
   output logic       carry_out
);

   // Ripple is combinational so a full 999999 -> 000000 roll completes in one cycle.
   assign carry_out = carry_in & (q == BCD_MAX);

   // Digit register: clear wins, then load (sanitised), then carry-gated increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= 4'd0;
      end else if (clear) begin
         q <= 4'd0;
      end else if (load) begin
         q <= bcd_sanitize(load_val);
      end else if (inc && carry_in) begin
         q <= (q == BCD_MAX) ? 4'd0 : q + 4'd1;
      end
   end

endmodule

// File: rtl/hex_count_sequencer.sv
// Six-digit BCD count controller feeding the 7-segment decoders.
// Single clock: prescaler tick enable, IDLE/RUN/PAUSE/DONE FSM, decimal carry
// chain, load, and wrap or saturate on overflow (WRAP parameter).
// Optional build macro LEADING_ZERO_BLANK_EN: registered leading-zero blank
// mask; when undefined, blank is tied to 0.
// Handshake: start/stop/clear/load_en are level commands sampled every clock,
// resolved by priority clear > stop > load_en > start; no ready/ack is returned.
module hex_count_sequencer
   import hex_count_pkg::*;
#(
   parameter int TICK_DIV = 50000000,
   parameter int WRAP     = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        stop,
   input  logic        clear,
   input  logic        load_en,
   input  logic [23:0] load_val,
   output logic [23:0] digits,
   output logic [5:0]  blank,
   output logic        running,
   output logic        tick,
   output logic        ovf,
   output logic [1:0]  state_dbg
);

   localparam int PW = $clog2(TICK_DIV);

   state_e          state;
   logic [PW-1:0]   presc;
   logic [NUM_DIGITS:0] carry;

   logic cmd_start;
   logic do_load;
   logic step;
   logic all_nine;
   logic inc_en;

   // A lower-priority command is only seen when no higher one is present, even
   // if that higher one is ignored in the current state (stop+start in PAUSE).
   assign cmd_start = start & ~stop & ~load_en & ~clear;
   assign do_load   = load_en & ~stop & ~clear & ((state == IDLE) || (state == PAUSE));
   // A count step needs a full prescaler period while staying in RUN.
   assign step      = (state == RUN) & ~clear & ~stop & (presc == PW'(TICK_DIV - 1));
   assign all_nine  = carry[NUM_DIGITS];
   // Saturating build holds 999999 instead of rolling over.
   assign inc_en    = step & ~(all_nine & (WRAP == 0));

   assign carry[0]  = 1'b1;
   assign state_dbg = state;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         bcd_digit u_digit (
            .clk       (clk),
            .rst_n     (rst_n),
            .clear     (clear),
            .load      (do_load),
            .load_val  (load_val[4*gi +: 4]),
            .inc       (inc_en),
            .carry_in  (carry[gi]),
            .q         (digits[4*gi +: 4]),
            .carry_out (carry[gi+1])
         );
      end
   endgenerate

   // Control FSM with prescaler, tick, overflow and running flag all registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         presc   <= '0;
         tick    <= 1'b0;
         ovf     <= 1'b0;
         running <= 1'b0;
      end else begin
         tick <= step;
         if (WRAP != 0) ovf <= 1'b0;
         if (clear) begin
            state   <= IDLE;
            presc   <= '0;
            ovf     <= 1'b0;
            running <= 1'b0;
         end else begin
            case (state)
               IDLE, PAUSE: begin
                  if (cmd_start) begin
                     state   <= RUN;
                     running <= 1'b1;
                  end
               end
               RUN: begin
                  if (stop) begin
                     state   <= PAUSE;
                     running <= 1'b0;
                  end else if (step) begin
                     presc <= '0;
                     if (all_nine) begin
                        ovf <= 1'b1;
                        if (WRAP == 0) begin
                           state   <= DONE;
                           running <= 1'b0;
                        end
                     end
                  end else begin
                     presc <= presc + PW'(1);
                  end
               end
               DONE: begin
                  presc <= '0;
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   logic [NUM_DIGITS-1:1] zero_nxt;
   logic [NUM_DIGITS-1:0] blank_nxt;
   logic                  all_hi_zero;

   // Predict which digits are zero after this edge so blank lines up with digits.
   always_comb begin
      zero_nxt    = '0;
      blank_nxt   = '0;
      all_hi_zero = 1'b1;
      for (int i = 1; i < NUM_DIGITS; i++) begin
         if (clear)
            zero_nxt[i] = 1'b1;
         else if (do_load)
            zero_nxt[i] = (bcd_sanitize(load_val[4*i +: 4]) == 4'd0);
         else if (inc_en && carry[i])
            zero_nxt[i] = (digits[4*i +: 4] == BCD_MAX);
         else
            zero_nxt[i] = (digits[4*i +: 4] == 4'd0);
      end
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         all_hi_zero  = all_hi_zero & zero_nxt[i];
         blank_nxt[i] = all_hi_zero;
      end
   end

   // Blank mask register; digit 0 always stays lit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) blank <= 6'b111110;
      else        blank <= blank_nxt;
   end
`else
   assign blank = '0;
`endif

endmodule

// File: tb/tb_hex_count_sequencer.sv
// Bench for hex_count_sequencer: two instances (wrap and saturate) share the
// same stimulus; an integer-valued reference model predicts every output.
module tb_hex_count_sequencer;
  import hex_count_pkg::*;

  localparam int TD = 4;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [5:0] BLANK_ZERO = 6'b111110;
`else
  localparam logic [5:0] BLANK_ZERO = 6'b000000;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0, stop = 1'b0, clear = 1'b0, load_en = 1'b0;
  logic [23:0] load_val = '0;

  logic [23:0] dig[2];
  logic [5:0]  blk[2];
  logic        run[2], tck[2], ov[2];
  logic [1:0]  st[2];

  int checks = 0;
  int errors = 0;

  hex_count_sequencer #(.TICK_DIV(TD), .WRAP(1)) u_wrap (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
    .load_en(load_en), .load_val(load_val), .digits(dig[0]), .blank(blk[0]),
    .running(run[0]), .tick(tck[0]), .ovf(ov[0]), .state_dbg(st[0]));

  hex_count_sequencer #(.TICK_DIV(TD), .WRAP(0)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
    .load_en(load_en), .load_val(load_val), .digits(dig[1]), .blank(blk[1]),
    .running(run[1]), .tick(tck[1]), .ovf(ov[1]), .state_dbg(st[1]));

  // ---------------- reference model ----------------
  state_e m_state[2];
  int     m_val[2];
  int     m_cnt[2];
  logic   m_tick[2];
  logic   m_ovf[2];

  function automatic int bcd_to_int(input logic [23:0] b);
    int v = 0;
    int p = 1;
    for (int i = 0; i < 6; i++) begin
      int nib = int'(b[4*i +: 4]);
      if (nib <= 9) v += nib * p;
      p *= 10;
    end
    return v;
  endfunction

  function automatic logic [23:0] int_to_bcd(input int v);
    logic [23:0] r = '0;
    int x = v;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [5:0] exp_blank(input int v);
    logic [5:0] b = '0;
`ifdef LEADING_ZERO_BLANK_EN
    int p = 10;
    for (int i = 1; i < 6; i++) begin
      b[i] = (v < p);
      p *= 10;
    end
`endif
    return b;
  endfunction

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      m_state[w] = IDLE;
      m_val[w]   = 0;
      m_cnt[w]   = 0;
      m_tick[w]  = 1'b0;
      m_ovf[w]   = 1'b0;
    end
  endtask

  // One clock edge of the model, using the command levels present at the edge.
  task automatic model_step(input int w, input bit wrap);
    m_tick[w] = 1'b0;
    if (wrap) m_ovf[w] = 1'b0;
    if (clear) begin
      m_state[w] = IDLE;
      m_val[w]   = 0;
      m_cnt[w]   = 0;
      m_ovf[w]   = 1'b0;
    end else if (m_state[w] == RUN) begin
      if (stop) begin
        m_state[w] = PAUSE;
      end else begin
        m_cnt[w]++;
        if (m_cnt[w] == TD) begin
          m_cnt[w]  = 0;
          m_tick[w] = 1'b1;
          if (m_val[w] == 999999) begin
            m_ovf[w] = 1'b1;
            if (wrap) m_val[w] = 0;
            else      m_state[w] = DONE;
          end else begin
            m_val[w]++;
          end
        end
      end
    end else if (m_state[w] == IDLE || m_state[w] == PAUSE) begin
      if (!stop) begin
        if (load_en)    m_val[w] = bcd_to_int(load_val);
        else if (start) m_state[w] = RUN;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model(input int w);
    check($sformatf("w%0d digits", w), 32'(dig[w]), 32'(int_to_bcd(m_val[w])));
    check($sformatf("w%0d blank", w), 32'(blk[w]), 32'(exp_blank(m_val[w])));
    check($sformatf("w%0d running", w), 32'(run[w]), 32'(m_state[w] == RUN));
    check($sformatf("w%0d tick", w), 32'(tck[w]), 32'(m_tick[w]));
    check($sformatf("w%0d ovf", w), 32'(ov[w]), 32'(m_ovf[w]));
    check($sformatf("w%0d state", w), 32'(st[w]), 32'(m_state[w]));
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) model_reset();
      else begin
        model_step(0, 1'b1);
        model_step(1, 1'b0);
      end
      #1;
      for (int w = 0; w < 2; w++) compare_model(w);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge: hold the command for one sampling edge, then release.
  task automatic drive(input logic s, input logic p, input logic c,
                       input logic l, input logic [23:0] lv);
    start = s; stop = p; clear = c; load_en = l; load_val = lv;
    @(negedge clk);
    start = 1'b0; stop = 1'b0; clear = 1'b0; load_en = 1'b0; load_val = '0;
  endtask

  task automatic check_reset_values(input string tag);
    for (int w = 0; w < 2; w++) begin
      check($sformatf("%s w%0d digits", tag, w), 32'(dig[w]), 32'h0);
      check($sformatf("%s w%0d blank", tag, w), 32'(blk[w]), 32'(BLANK_ZERO));
      check($sformatf("%s w%0d tick", tag, w), 32'(tck[w]), 32'h0);
      check($sformatf("%s w%0d ovf", tag, w), 32'(ov[w]), 32'h0);
      check($sformatf("%s w%0d running", tag, w), 32'(run[w]), 32'h0);
      check($sformatf("%s w%0d state", tag, w), 32'(st[w]), 32'(IDLE));
    end
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    wait_neg(3);
    check_reset_values("reset");
    rst_n = 1'b1;

    // tick timing: steps at TD, 2*TD, 3*TD after the RUN-entry edge
    drive(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
    check("run entry running", 32'(run[0]), 32'h1);
    wait_neg(3);
    check("no tick before TD", 32'(tck[0]), 32'h0);
    wait_neg(1);
    check("tick1", 32'(tck[0]), 32'h1);
    check("digits1", 32'(dig[0]), 32'h000001);
    wait_neg(4);
    check("digits2", 32'(dig[0]), 32'h000002);
    wait_neg(4);
    check("tick3", 32'(tck[0]), 32'h1);
    check("digits3", 32'(dig[0]), 32'h000003);
    check("running3", 32'(run[0]), 32'h1);

    // asynchronous reset in the middle of a count
    wait_neg(2);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_values("midreset");
    wait_neg(2);
    rst_n = 1'b1;

    // pause after two prescaler cycles, resume continues the partial count
    drive(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
    wait_neg(2);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
    check("pause state", 32'(st[0]), 32'(PAUSE));
    wait_neg(20);
    check("pause no count", 32'(dig[0]), 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
    wait_neg(1);
    check("resume no tick yet", 32'(tck[0]), 32'h0);
    wait_neg(1);
    check("resume tick", 32'(tck[0]), 32'h1);
    check("resume digits", 32'(dig[0]), 32'h000001);

    // carry chain, wrap and saturate
    drive(1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 24'h999998);
    check("load 999998", 32'(dig[1]), 32'h999998);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
    wait_neg(4);
    check("wrap 999999", 32'(dig[0]), 32'h999999);
    wait_neg(4);
    check("wrap digits", 32'(dig[0]), 32'h000000);
    check("wrap ovf", 32'(ov[0]), 32'h1);
    check("wrap tick", 32'(tck[0]), 32'h1);
    check("wrap state", 32'(st[0]), 32'(RUN));
    check("sat digits", 32'(dig[1]), 32'h999999);
    check("sat state", 32'(st[1]), 32'(DONE));
    check("sat tick", 32'(tck[1]), 32'h1);
    wait_neg(1);
    check("wrap ovf pulse", 32'(ov[0]), 32'h0);
    check("sat ovf sticky", 32'(ov[1]), 32'h1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
    check("done ignores start", 32'(st[1]), 32'(DONE));
    drive(1'b0, 1'b0, 1'b1, 1'b0, 24'h0);
    check("clear ovf", 32'(ov[1]), 32'h0);
    check("clear state", 32'(st[1]), 32'(IDLE));
    check("clear digits", 32'(dig[1]), 32'h0);

    // sanitised load
    drive(1'b0, 1'b0, 1'b0, 1'b1, 24'h00A0F3);
    check("sanitize digits", 32'(dig[0]), 32'h000003);
    check("sanitize blank", 32'(blk[0]), 32'(BLANK_ZERO));

    // clear+stop+start together in RUN
    drive(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
    wait_neg(5);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 24'h0);
    check("priority state", 32'(st[0]), 32'(IDLE));
    check("priority digits", 32'(dig[0]), 32'h0);

    // load ignored in RUN
    drive(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
    wait_neg(5);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 24'h123456);
    check("run load ignored", 32'(dig[0]), 32'h000001);

    // stop+start together in PAUSE stays paused
    drive(1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 24'h0);
    check("pause stop+start", 32'(st[0]), 32'(PAUSE));

    // random commands, checked each cycle by the model
    for (int n = 0; n < 3000; n++) begin
      clear   = ($urandom_range(0, 99) < 2);
      stop    = ($urandom_range(0, 99) < 6);
      load_en = ($urandom_range(0, 99) < 6);
      start   = ($urandom_range(0, 99) < 20);
      if ($urandom_range(0, 1) == 0)
        load_val = {20'h99999, 4'($urandom_range(5, 15))};
      else
        load_val = 24'($urandom());
      @(negedge clk);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 24'h0);
    wait_neg(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hex_count_sequencer.md
Name: hex_count_sequencer

Overview:
Six-digit BCD count controller that sequences the per-digit values driven into the six 7-segment hex decoders on the board. It replaces a free-running single-digit counter and divided clock with a single-clock design: a prescaler tick enable, a run/pause/clear FSM, a decimal carry chain across six digits, load, and overflow handling. Outputs are raw BCD nibbles plus a blank mask; the existing 7-segment decoders consume them unchanged.

Parameters:
TICK_DIV, 50000000, clock cycles per count step (1 Hz at 50 MHz); legal range ≥ 2
WRAP, 1, 1 = 999999 rolls over to 000000; 0 = saturate at 999999 and enter DONE

Ports:
clk  input  1  system clock (MAX10_CLK1_50 at top level)
rst_n  input  1  asynchronous active-low reset
start  input  1  level-sampled command: enter/resume RUN
stop  input  1  level-sampled command: RUN -> PAUSE
clear  input  1  level-sampled command: zero everything, go IDLE
load_en  input  1  load load_val into digits
load_val  input  24  six BCD nibbles, [3:0] = digit 0 (least significant)
digits  output  24  current BCD value, [3:0] = digit 0 -> HEX0
blank  output  6  per-digit blank request, bit i = HEXi off
running  output  1  1 while state = RUN
tick  output  1  one-cycle pulse on every count step
ovf  output  1  overflow flag (pulse or sticky, see below)

Behaviour:
- Reset (rst_n low, async): state IDLE, digits 0, prescaler 0, tick 0, ovf 0, running 0, blank 6'b111110 with LEADING_ZERO_BLANK_EN defined, else 0.
- States: IDLE, RUN, PAUSE, DONE. All outputs registered.
- Command priority each cycle: clear > stop > load_en > start.
- clear (any state): next state IDLE; digits, prescaler, ovf = 0.
- stop: RUN -> PAUSE; ignored in other states.
- start: IDLE/PAUSE -> RUN; ignored in RUN and DONE (DONE exits only via clear).
- stop and start high together in PAUSE: remain in PAUSE.
- load_en: accepted only in IDLE/PAUSE; ignored in RUN/DONE. Any nibble > 9 is stored as 0. State unchanged; prescaler unchanged.
- Prescaler: counts only in RUN, holds in PAUSE, is 0 in IDLE/DONE. When it equals TICK_DIV-1 it returns to 0. On that same edge, tick registers to 1 for one cycle and digits increment by one.
- First tick occurs TICK_DIV cycles after the RUN-entry edge. Resuming from PAUSE continues the partial prescaler count.
- Increment: digit i increments iff all lower digits = 9. A digit at 9 with carry-in becomes 0. Full ripple completes in the same cycle.
- 999999 + step:
  - WRAP=1: digits -> 000000; ovf pulses high for one cycle together with tick; stays in RUN.
  - WRAP=0: digits hold 999999; state -> DONE; tick still pulses; ovf set sticky until clear or reset.
- running = (state == RUN), registered with the state.
- Reset asserted mid-count: immediate return to reset values; no tick or ovf glitch is emitted.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: blank[i] = 1 when digit i and all higher digits are 0, for i = 5..1. blank[0] is always 0, so value 0 shows a single "0". blank is registered and updated on the same edge as digits.
- Undefined: blank is constant 0 (all six digits always lit), and no blanking logic is generated.

Decomposition:
- Package hex_count_pkg holds:
  - state enum (IDLE, RUN, PAUSE, DONE)
  - NUM_DIGITS = 6
  - BCD_MAX = 4'd9
  - helper function bcd_sanitize (nibble > 9 -> 0)
- Sub-module bcd_digit: one 4-bit BCD register with inc, carry_in, load, load_val, and clear inputs and a carry_out output; instantiated six times in a carry chain.
- FSM and prescaler stay in the top module.

Test Plan:
- Reset mid-RUN: TICK_DIV=4; start, wait 10 cycles, pulse rst_n low -> digits=0, state IDLE, tick/ovf/running=0 immediately; blank=6'b111110 (feature on).
- Tick timing: TICK_DIV=4; start at cycle 0 -> tick high at cycles 4, 8, 12; digits 000001, 000002, 000003; running=1 throughout.
- Pause/resume: start, stop after 2 prescaler cycles, hold PAUSE 20 cycles, start -> no tick during PAUSE; next tick 2 cycles after resume.
- Carry and wrap: WRAP=1; load 0x999998 in PAUSE, start -> 999999, then 000000 with ovf and tick both high for one cycle; state stays RUN.
- Saturate: WRAP=0; load 0x999999, start -> after TICK_DIV cycles digits stay 999999, state DONE, ovf=1 sticky; start ignored; clear -> IDLE, ovf=0, digits 0.
- Priority/sanitize:
  - clear+stop+start together in RUN -> IDLE, digits 0.
  - load_en with load_val=0x00A0F3 in IDLE -> digits 0x000003; blank=6'b111110 (feature on) or 0 (off).
  - load_en in RUN -> ignored.
